// File: rtl/spi_ram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_ram_bridge_pkg
// Purpose : Command codes, FSM state encoding and width helper for the
//           SPI-slave-to-RAM bridge.
// Revision: 1.0 - initial release
// ============================================================================
package spi_ram_bridge_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RX   = 3'd1,
        ST_EXEC = 3'd2,
        ST_LOAD = 3'd3,
        ST_TX   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_ram_bridge_if
// Purpose : Serial frame bus between an SPI master and the RAM bridge.
// Revision: 1.0 - initial release
// ============================================================================
interface spi_ram_bridge_if;

    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic frame_abort;

    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  busy,
        input  frame_abort
    );

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output busy,
        output frame_abort
    );

endinterface
`default_nettype wire

// File: rtl/spi_ram_bridge_mem.sv
`default_nettype none
// ============================================================================
// Module  : spi_ram_bridge_mem
// Purpose : Single-port synchronous RAM with registered read data; the array
//           itself has no reset.
// Revision: 1.0 - initial release
// ============================================================================
module spi_ram_bridge_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_din,
    output logic      [DATA_WIDTH-1:0] o_dout
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [DATA_WIDTH-1:0] r_dout;

    // Read-before-write on a shared address
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
        r_dout <= r_mem[i_addr];
    end

    assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/spi_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module  : spi_ram_bridge
// Purpose : SPI slave (bit clock = clk) decoding 2-bit command frames that
//           set addresses and write/read an internal RAM.
// Revision: 1.0 - initial release
// ============================================================================
module spi_ram_bridge
    import spi_ram_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    spi_ram_bridge_if.slave  bus
);

    localparam int c_pw     = max_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int c_sr_w   = c_pw + 2;
    localparam int c_cnt_w  = $clog2(c_sr_w + 1);
    localparam int c_tx_w   = $clog2(DATA_WIDTH + 1);

    localparam logic [c_cnt_w-1:0]    c_last_bit = c_cnt_w'(c_sr_w - 1);
    localparam logic [c_tx_w-1:0]     c_last_tx  = c_tx_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_tx_w-1:0]     c_tx_one   = c_tx_w'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    state_t                r_state;
    logic [c_sr_w-1:0]     r_shift_in;
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift_out;
    logic [c_tx_w-1:0]     r_tx_cnt;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_miso;
    logic                  r_busy;
    logic                  r_abort;

    cmd_t                  w_cmd;
    logic                  w_in_frame;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_dout;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [ADDR_WIDTH-1:0] w_wr_addr_inc;
    logic [ADDR_WIDTH-1:0] w_rd_addr_inc;

    assign w_cmd        = cmd_t'(r_shift_in[c_sr_w-1 -: 2]);
    assign w_in_frame   = (r_state == ST_RX) || (r_state == ST_EXEC) ||
                          (r_state == ST_LOAD) || (r_state == ST_TX);
    // The write strobe must honour both reset priority and abort-in-EXEC
    assign w_mem_we     = (r_state == ST_EXEC) && !bus.SS_n && !rst &&
                          (w_cmd == CMD_WR_DATA);
    assign w_mem_addr   = ((r_state == ST_EXEC) && (w_cmd == CMD_WR_DATA)) ?
                          r_wr_addr : r_rd_addr;
    assign w_shift_next = r_shift_out << 1;

    generate
        if (AUTO_INC != 0) begin : g_auto_inc
            assign w_wr_addr_inc = r_wr_addr + c_addr_one;
            assign w_rd_addr_inc = r_rd_addr + c_addr_one;
        end else begin : g_no_inc
            assign w_wr_addr_inc = r_wr_addr;
            assign w_rd_addr_inc = r_rd_addr;
        end
    endgenerate

    spi_ram_bridge_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_mem_we),
        .i_addr (w_mem_addr),
        .i_din  (r_shift_in[DATA_WIDTH-1:0]),
        .o_dout (w_mem_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift_in  <= '0;
            r_bit_cnt   <= '0;
            r_shift_out <= '0;
            r_tx_cnt    <= '0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            if (w_in_frame && bus.SS_n) begin
                r_state   <= ST_IDLE;
                r_abort   <= 1'b1;
                r_busy    <= 1'b0;
                r_miso    <= 1'b0;
                r_bit_cnt <= '0;
                r_tx_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!bus.SS_n) begin
                            r_shift_in <= {r_shift_in[c_sr_w-2:0], bus.MOSI};
                            r_bit_cnt  <= c_cnt_one;
                            r_busy     <= 1'b1;
                            r_state    <= ST_RX;
                        end
                    end
                    ST_RX: begin
                        r_shift_in <= {r_shift_in[c_sr_w-2:0], bus.MOSI};
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_EXEC;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_cnt_one;
                        end
                    end
                    ST_EXEC: begin
                        case (w_cmd)
                            CMD_WR_ADDR: r_wr_addr <= r_shift_in[ADDR_WIDTH-1:0];
                            CMD_WR_DATA: r_wr_addr <= w_wr_addr_inc;
                            CMD_RD_ADDR: r_rd_addr <= r_shift_in[ADDR_WIDTH-1:0];
                            CMD_RD_DATA: r_rd_addr <= w_rd_addr_inc;
                            default: ;
                        endcase
                        if (w_cmd == CMD_RD_DATA) begin
                            r_state <= ST_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_LOAD: begin
                        r_shift_out <= w_mem_dout;
                        r_miso      <= w_mem_dout[DATA_WIDTH-1];
                        r_tx_cnt    <= '0;
                        r_state     <= ST_TX;
                    end
                    ST_TX: begin
                        if (r_tx_cnt == c_last_tx) begin
                            r_miso  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_shift_out <= w_shift_next;
                            r_miso      <= w_shift_next[DATA_WIDTH-1];
                            r_tx_cnt    <= r_tx_cnt + c_tx_one;
                        end
                    end
                    ST_DONE: begin
                        if (bus.SS_n) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.MISO        = r_miso;
    assign bus.busy        = r_busy;
    assign bus.frame_abort = r_abort;

endmodule
`default_nettype wire

// File: doc/spi_ram_bridge.md
# spi_ram_bridge

Parametrised SPI-slave-to-RAM bridge: a serial frame protocol drives an internal single-port RAM of configurable depth and width, with optional address auto-increment. It replaces the fixed 8-bit/256-word slave+RAM pairing as the standard serial-accessible memory endpoint in the design. The SPI bit clock is the system clock: MOSI is sampled and MISO is driven on rising `clk`.

## Interface
- ADDR_WIDTH, 8, RAM address bits; DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 8, RAM word width
- AUTO_INC, 0, 1 = post-increment the relevant address after each data write/read
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- SS_n  in  1  slave select, active-low, frames a transaction
- MOSI  in  1  serial data in, MSB first
- MISO  out  1  serial data out, MSB first; 0 when not shifting
- busy  out  1  high while a frame is in progress (state != IDLE/DONE)
- frame_abort  out  1  one-cycle pulse when SS_n rises mid-frame

## Operation
- PW = max(ADDR_WIDTH, DATA_WIDTH). Frame = 2 command bits + PW payload bits, MSB first, one bit per `clk` edge with SS_n low.
- Commands: 00 set write address; 01 write data; 10 set read address; 11 read data (payload is dummy).
- Address payloads use payload[ADDR_WIDTH-1:0]; data payloads use payload[DATA_WIDTH-1:0]; upper bits ignored.
- States: IDLE -> RX (SS_n low; bit counter 0..PW+1) -> EXEC (after last payload bit) -> DONE for 00/01/10; 11 goes EXEC -> LOAD -> TX (DATA_WIDTH cycles) -> DONE. DONE waits for SS_n high, ignores further MOSI, then IDLE.
- EXEC: 00 loads wr_addr; 01 writes mem[wr_addr]; 10 loads rd_addr; 11 registers mem[rd_addr].
- AUTO_INC=1: wr_addr += 1 after 01, rd_addr += 1 after 11; wrap DEPTH-1 -> 0. AUTO_INC=0: addresses change only via 00/10.
- SS_n high in RX, EXEC, LOAD or TX: return to IDLE next edge, pulse frame_abort, no RAM write, no address change, MISO -> 0. Abort in EXEC suppresses the EXEC action.
- A bit is captured only on edges where SS_n is low.
- Reset: state IDLE, MISO 0, busy 0, frame_abort 0, wr_addr 0, rd_addr 0, counters 0. RAM contents not reset. rst wins over all other inputs; reset mid-frame discards the frame without abort pulse.

## Timing
- Edge numbering from the first edge sampling SS_n low as edge 1: command bits edges 1-2, payload edges 3..PW+2.
- EXEC at edge PW+3: RAM write / address load / RAM read registered.
- Read data: LOAD at edge PW+4 loads shift register; MISO = data[DATA_WIDTH-1] after edge PW+4, bit 0 after edge PW+DATA_WIDTH+3, MISO 0 after edge PW+DATA_WIDTH+4 (state DONE).
- Write data visible to a read-data frame starting the cycle after EXEC.
- busy rises after edge 1, falls on entry to DONE or IDLE.
- Back-to-back frames: SS_n high for ≥1 edge between frames.

## Structure
- Package spi_ram_bridge_pkg: 2-bit command codes (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), state enum.
- Sub-module spi_ram_bridge_mem: parametrised single-port synchronous RAM (we, addr, din, registered dout), no reset on array.
- Top holds FSM, bit counter, shift-in/shift-out registers, address registers.

## Test plan
- Defaults: frames 00+0x12, 01+0xA5, 10+0x12, 11+0x00 -> MISO 1,0,1,0,0,1,0,1 after edges 12..19, MISO 0 after edge 20.
- AUTO_INC=1, ADDR_WIDTH=2: write addr 0x3, write 0x11 then 0x22 -> mem[3]=0x11, mem[0]=0x22 (wrap); read from addr 3 twice -> 0x11, 0x22.
- SS_n raised after payload edge 6 of a 01 frame -> frame_abort pulse, mem[wr_addr] unchanged, busy 0, next frame decodes normally.
- rst asserted during TX of 0xA5 -> MISO 0 next edge, rd_addr/wr_addr 0, no abort pulse; mem contents retained.
- ADDR_WIDTH=10, DATA_WIDTH=16: write 0xBEEF at 0x3FF, read back -> 16 MISO bits 0xBEEF starting after edge 20.
- Extra MOSI bits in DONE with SS_n low -> ignored, no RAM write, MISO 0.
